pcie_fifo_drain_ctrl: RTL and testbench

//  Read-side scheduler for the 16->128-bit video capture FIFO (pcie_fifo, 512 x 128-bit read side).

---
 rtl/pcie_fifo_drain_ctrl_pkg.sv | 18 +
 rtl/pcie_fifo_drain_ctrl_skid.sv | 49 ++++
 rtl/pcie_fifo_drain_ctrl.sv | 161 ++++++++++++++++
 tb/tb_pcie_fifo_drain_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcie_fifo_drain_ctrl_pkg.sv
// Shared types and constants for the pcie_fifo read-side drain controller.
package pcie_fifo_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        REQ,
        XFER
    } state_t;

    localparam int unsigned DEFAULT_RD_DATA_WIDTH = 128;
    localparam int unsigned BEAT_BYTES            = DEFAULT_RD_DATA_WIDTH / 8;

    function automatic int unsigned beat_bytes(input int unsigned data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/pcie_fifo_drain_ctrl_skid.sv
// Two-entry buffer between the FIFO read port and the DMA beat stream.
module pcie_drain_skid
    import pcie_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 128
) (
    input  logic                  clk,
    input  logic                  tb_rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  push_last,
    input  logic                  pop,
    output logic [1:0]            count,
    output logic [DATA_WIDTH-1:0] head_data,
    output logic                  head_last
);

    logic [DATA_WIDTH-1:0] r_data [2];
    logic [1:0]            r_last;
    logic                  r_rd_ptr;
    logic                  r_wr_ptr;
    logic [1:0]            r_count;

    always_ff @(posedge clk or posedge tb_rst) begin
        if (tb_rst) begin
            r_data[0] <= '0;
            r_data[1] <= '0;
            r_last    <= '0;
            r_rd_ptr  <= 1'b0;
            r_wr_ptr  <= 1'b0;
            r_count   <= '0;
        end else begin
            if (push) begin
                r_data[r_wr_ptr] <= push_data;
                r_last[r_wr_ptr] <= push_last;
                r_wr_ptr         <= ~r_wr_ptr;
            end
            if (pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, push} - {1'b0, pop};
        end
    end

    assign count     = r_count;
    assign head_data = r_data[r_rd_ptr];
    assign head_last = r_last[r_rd_ptr];

endmodule

// File: rtl/pcie_fifo_drain_ctrl.sv
// Drains the video capture FIFO into PCIe DMA bursts: watches the level,
// requests a burst, pops exactly the granted beats and streams them out.
module pcie_fifo_drain_ctrl
    import pcie_fifo_pkg::*;
#(
    parameter int unsigned RD_DEPTH_WIDTH = 9,
    parameter int unsigned RD_DATA_WIDTH  = 128,
    parameter int unsigned BURST_LEN      = 32,
    parameter int unsigned LEN_WIDTH      = 8,
    parameter int unsigned ADDR_WIDTH     = 32
) (
    input  logic                     clk,
    input  logic                     tb_rst,
    input  logic                     enable,
    input  logic [ADDR_WIDTH-1:0]    base_addr,
    input  logic                     frame_end,
    input  logic [RD_DEPTH_WIDTH:0]  fifo_rd_level,
    input  logic                     fifo_rd_empty,
    input  logic                     fifo_wr_full,
    output logic                     fifo_rd_en,
    input  logic [RD_DATA_WIDTH-1:0] fifo_rd_data,
    output logic                     dma_req,
    output logic [ADDR_WIDTH-1:0]    dma_addr,
    output logic [LEN_WIDTH-1:0]     dma_len,
    input  logic                     dma_gnt,
    output logic                     dma_valid,
    output logic [RD_DATA_WIDTH-1:0] dma_data,
    output logic                     dma_last,
    input  logic                     dma_ready,
    output logic                     frame_done,
    output logic                     overflow,
    input  logic                     ovf_clr,
    output logic                     busy
);

    localparam int unsigned          BYTES_PER_BEAT = beat_bytes(RD_DATA_WIDTH);
    localparam logic [RD_DEPTH_WIDTH:0] BURST_LVL   = (RD_DEPTH_WIDTH + 1)'(BURST_LEN);
    localparam logic [LEN_WIDTH-1:0] BURST_LENV     = LEN_WIDTH'(BURST_LEN);

    state_t                 r_state;
    logic [ADDR_WIDTH-1:0]  r_addr;
    logic [LEN_WIDTH-1:0]   r_len;
    logic [LEN_WIDTH-1:0]   r_issued;
    logic                   r_req;
    logic                   r_inflight;
    logic                   r_inflight_last;
    logic                   r_flush_pend;
    logic                   r_frame_done;
    logic                   r_overflow;

    logic [1:0]             w_count;
    logic                   w_head_last;
    logic                   w_valid;
    logic                   w_deq;
    logic [2:0]             w_occ;
    logic                   w_pop;

    assign w_valid = (w_count != 2'd0);
    assign w_deq   = w_valid && dma_ready;
    // Occupancy seen by the next cycle: a beat leaving now frees its slot for a pop now.
    assign w_occ   = {1'b0, w_count} + {2'b00, r_inflight} - {2'b00, w_deq};
    assign w_pop   = (r_state == XFER) && (r_issued < r_len) && !fifo_rd_empty && (w_occ < 3'd2);

    pcie_drain_skid #(
        .DATA_WIDTH (RD_DATA_WIDTH)
    ) u_skid (
        .clk       (clk),
        .tb_rst    (tb_rst),
        .push      (r_inflight),
        .push_data (fifo_rd_data),
        .push_last (r_inflight_last),
        .pop       (w_deq),
        .count     (w_count),
        .head_data (dma_data),
        .head_last (w_head_last)
    );

    always_ff @(posedge clk or posedge tb_rst) begin
        if (tb_rst) begin
            r_state         <= IDLE;
            r_addr          <= '0;
            r_len           <= '0;
            r_issued        <= '0;
            r_req           <= 1'b0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
            r_flush_pend    <= 1'b0;
            r_frame_done    <= 1'b0;
            r_overflow      <= 1'b0;
        end else begin
            if (fifo_wr_full) begin
                r_overflow <= 1'b1;
            end else if (ovf_clr) begin
                r_overflow <= 1'b0;
            end

            r_frame_done    <= 1'b0;
            r_inflight      <= w_pop;
            r_inflight_last <= w_pop && (r_issued == r_len - LEN_WIDTH'(1));
            if (w_pop) begin
                r_issued <= r_issued + LEN_WIDTH'(1);
            end

            case (r_state)
                IDLE: begin
                    if (enable) begin
                        r_state <= ARM;
                        r_addr  <= base_addr;
                    end
                end
                ARM: begin
                    if (!enable) begin
                        r_state <= IDLE;
                    end else if (fifo_rd_level >= BURST_LVL) begin
                        r_state <= REQ;
                        r_len   <= BURST_LENV;
                        r_req   <= 1'b1;
                    end else if (r_flush_pend && (fifo_rd_level != '0)) begin
                        r_state <= REQ;
                        r_len   <= LEN_WIDTH'(fifo_rd_level);
                        r_req   <= 1'b1;
                    end else if (r_flush_pend) begin
                        r_frame_done <= 1'b1;
                        r_flush_pend <= 1'b0;
                        r_addr       <= base_addr;
                    end
                end
                REQ: begin
                    if (dma_gnt) begin
                        r_state  <= XFER;
                        r_req    <= 1'b0;
                        r_issued <= '0;
                    end
                end
                XFER: begin
                    if (w_deq && w_head_last) begin
                        r_state <= ARM;
                        r_addr  <= r_addr + ADDR_WIDTH'(r_len) * ADDR_WIDTH'(BYTES_PER_BEAT);
                    end
                end
                default: r_state <= IDLE;
            endcase

            // A new frame_end must not be lost to a flush completing in the same cycle.
            if (frame_end) begin
                r_flush_pend <= 1'b1;
            end
        end
    end

    assign fifo_rd_en = w_pop;
    assign dma_req    = r_req;
    assign dma_addr   = r_addr;
    assign dma_len    = r_len;
    assign dma_valid  = w_valid;
    assign dma_last   = w_valid && w_head_last;
    assign frame_done = r_frame_done;
    assign overflow   = r_overflow;
    assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_pcie_fifo_drain_ctrl.sv
// Directed bench for pcie_fifo_drain_ctrl with a behavioural FIFO read port.
module tb_pcie_fifo_drain_ctrl;

    logic         clk = 1'b0;
    logic         tb_rst;
    logic         enable;
    logic [31:0]  base_addr;
    logic         frame_end;
    logic [9:0]   fifo_rd_level;
    logic         fifo_rd_empty;
    logic         fifo_wr_full;
    logic         fifo_rd_en;
    logic [127:0] fifo_rd_data;
    logic         dma_req;
    logic [31:0]  dma_addr;
    logic [7:0]   dma_len;
    logic         dma_gnt;
    logic         dma_valid;
    logic [127:0] dma_data;
    logic         dma_last;
    logic         dma_ready;
    logic         frame_done;
    logic         overflow;
    logic         ovf_clr;
    logic         busy;

    int total = 0;
    int bad   = 0;

    int wr_idx = 0;
    int rd_idx = 0;

    int exp_idx    = 0;
    int order_err  = 0;
    int empty_viol = 0;
    int b_pops     = 0;
    int b_beats    = 0;
    int b_lasts    = 0;
    int b_last_at  = -1;
    int b_cyc      = 0;
    int occ        = 0;
    int b_maxocc   = 0;
    bit in_burst   = 1'b0;
    bit burst_done = 1'b0;

    pcie_fifo_drain_ctrl #(
        .RD_DEPTH_WIDTH (9),
        .RD_DATA_WIDTH  (128),
        .BURST_LEN      (32),
        .LEN_WIDTH      (8),
        .ADDR_WIDTH     (32)
    ) dut (
        .clk           (clk),
        .tb_rst        (tb_rst),
        .enable        (enable),
        .base_addr     (base_addr),
        .frame_end     (frame_end),
        .fifo_rd_level (fifo_rd_level),
        .fifo_rd_empty (fifo_rd_empty),
        .fifo_wr_full  (fifo_wr_full),
        .fifo_rd_en    (fifo_rd_en),
        .fifo_rd_data  (fifo_rd_data),
        .dma_req       (dma_req),
        .dma_addr      (dma_addr),
        .dma_len       (dma_len),
        .dma_gnt       (dma_gnt),
        .dma_valid     (dma_valid),
        .dma_data      (dma_data),
        .dma_last      (dma_last),
        .dma_ready     (dma_ready),
        .frame_done    (frame_done),
        .overflow      (overflow),
        .ovf_clr       (ovf_clr),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] word(input int i);
        logic [31:0] v;
        v = 32'hC0DE_0000 + 32'(i);
        return {v, ~v, v ^ 32'h5A5A_5A5A, 32'(i) * 32'd7};
    endfunction

    // FIFO read side: level tracks writes minus pops, data one cycle after pop.
    always_comb begin
        fifo_rd_level = 10'(wr_idx - rd_idx);
        fifo_rd_empty = (wr_idx == rd_idx);
    end

    always @(posedge clk or posedge tb_rst) begin
        if (tb_rst) begin
            rd_idx <= 0;
        end else if (fifo_rd_en) begin
            fifo_rd_data <= word(rd_idx);
            rd_idx       <= rd_idx + 1;
        end
    end

    // Stream monitor; values at the falling edge are what the next rising edge samples.
    always @(negedge clk) begin
        if (tb_rst) begin
            exp_idx  = 0;
            occ      = 0;
            in_burst = 1'b0;
        end else begin
            if (dma_req && dma_gnt) begin
                b_pops     = 0;
                b_beats    = 0;
                b_lasts    = 0;
                b_last_at  = -1;
                b_cyc      = 0;
                b_maxocc   = 0;
                in_burst   = 1'b1;
                burst_done = 1'b0;
            end else if (in_burst) begin
                b_cyc = b_cyc + 1;
            end
            if (fifo_rd_en) begin
                b_pops = b_pops + 1;
                occ    = occ + 1;
                if (fifo_rd_empty) empty_viol = empty_viol + 1;
            end
            if (dma_valid && dma_ready) begin
                if (dma_data !== word(exp_idx)) order_err = order_err + 1;
                exp_idx = exp_idx + 1;
                occ     = occ - 1;
                b_beats = b_beats + 1;
                if (dma_last) begin
                    b_lasts    = b_lasts + 1;
                    b_last_at  = b_beats;
                    burst_done = 1'b1;
                    in_burst   = 1'b0;
                end
            end
            if (occ > b_maxocc) b_maxocc = occ;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_req(input string tag, input logic [31:0] addr, input int len);
        for (int k = 0; k < 64 && !dma_req; k++) tick();
        chkb({tag, "_req"}, dma_req, 1'b1);
        chkw({tag, "_addr"}, 128'(dma_addr), 128'(addr));
        chki({tag, "_len"}, int'(dma_len), len);
    endtask

    task automatic grant_and_drain(input string tag, input bit rand_ready);
        dma_gnt = 1'b1;
        tick();
        dma_gnt = 1'b0;
        for (int k = 0; k < 400 && !burst_done; k++) begin
            if (rand_ready) dma_ready = 1'($urandom_range(0, 1));
            tick();
        end
        dma_ready = 1'b1;
        chkb({tag, "_done"}, burst_done, 1'b1);
    endtask

    initial begin
        int req_hi;
        int fd_cnt;

        tb_rst       = 1'b1;
        enable       = 1'b0;
        base_addr    = 32'h1000_0000;
        frame_end    = 1'b0;
        fifo_wr_full = 1'b0;
        dma_gnt      = 1'b0;
        dma_ready    = 1'b1;
        ovf_clr      = 1'b0;
        tick();
        tick();

        chkb("rst_req", dma_req, 1'b0);
        chkb("rst_valid", dma_valid, 1'b0);
        chkb("rst_rd_en", fifo_rd_en, 1'b0);
        chkw("rst_addr", 128'(dma_addr), '0);
        chkb("rst_busy", busy, 1'b0);
        chkb("rst_ovf", overflow, 1'b0);
        tb_rst = 1'b0;
        tick();

        // Level one short of a burst never requests.
        enable = 1'b1;
        wr_idx = 31;
        req_hi = 0;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (dma_req) req_hi++;
        end
        chki("t1_no_req", req_hi, 0);
        chkb("t1_busy", busy, 1'b1);

        // Full burst at ready=1: 32 pops, 32 beats, last on beat 32, 1 beat/clk.
        wr_idx = 32;
        wait_req("t2", 32'h1000_0000, 32);
        grant_and_drain("t2", 1'b0);
        chki("t2_pops", b_pops, 32);
        chki("t2_beats", b_beats, 32);
        chki("t2_last_at", b_last_at, 32);
        chki("t2_lasts", b_lasts, 1);
        chki("t2_order", order_err, 0);
        chki("t2_cycles", b_cyc, 34);
        chkw("t2_next_addr", 128'(dma_addr), 128'(32'h1000_0200));

        // Random backpressure.
        wr_idx = 64;
        wait_req("t3", 32'h1000_0200, 32);
        grant_and_drain("t3", 1'b1);
        chki("t3_pops", b_pops, 32);
        chki("t3_beats", b_beats, 32);
        chki("t3_last_at", b_last_at, 32);
        chki("t3_order", order_err, 0);
        chkb("t3_maxocc_le2", (b_maxocc <= 2), 1'b1);
        chkw("t3_next_addr", 128'(dma_addr), 128'(32'h1000_0400));

        // Flush of a 5-word tail, frame_end pulsed twice.
        wr_idx = 69;
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
        tick();
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
        wait_req("t4", 32'h1000_0400, 5);
        grant_and_drain("t4", 1'b0);
        chki("t4_pops", b_pops, 5);
        chki("t4_last_at", b_last_at, 5);
        chki("t4_order", order_err, 0);
        fd_cnt = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (frame_done) fd_cnt++;
        end
        chki("t4_frame_done", fd_cnt, 1);
        chkw("t4_addr_base", 128'(dma_addr), 128'(32'h1000_0000));
        chkb("t4_no_req", dma_req, 1'b0);

        // Overflow flag: set, set-wins-over-clear, then clear.
        fifo_wr_full = 1'b1;
        tick();
        fifo_wr_full = 1'b0;
        chkb("t5_set", overflow, 1'b1);
        fifo_wr_full = 1'b1;
        ovf_clr      = 1'b1;
        tick();
        fifo_wr_full = 1'b0;
        ovf_clr      = 1'b0;
        chkb("t5_set_wins", overflow, 1'b1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chkb("t5_clear", overflow, 1'b0);

        // Asynchronous reset in the middle of a burst.
        wr_idx = 101;
        wait_req("t6a", 32'h1000_0000, 32);
        dma_gnt = 1'b1;
        tick();
        dma_gnt = 1'b0;
        for (int k = 0; k < 100 && b_beats < 10; k++) tick();
        chki("t6_beats_before_rst", b_beats, 10);
        #2;
        tb_rst = 1'b1;
        #1;
        chkb("t6_req", dma_req, 1'b0);
        chkb("t6_valid", dma_valid, 1'b0);
        chkb("t6_rd_en", fifo_rd_en, 1'b0);
        chkb("t6_last", dma_last, 1'b0);
        chkw("t6_data", dma_data, '0);
        chkw("t6_addr", 128'(dma_addr), '0);
        chki("t6_len", int'(dma_len), 0);
        chkb("t6_busy", busy, 1'b0);
        wr_idx = 0;
        tick();
        tick();
        tb_rst = 1'b0;
        tick();
        wr_idx = 32;
        wait_req("t6b", 32'h1000_0000, 32);
        grant_and_drain("t6b", 1'b0);
        chki("t6b_pops", b_pops, 32);
        chki("t6b_last_at", b_last_at, 32);
        chki("t6b_order", order_err, 0);
        chkw("t6b_next_addr", 128'(dma_addr), 128'(32'h1000_0200));
        chki("empty_pops", empty_viol, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
